// File: rtl/prod_accum.sv
`default_nettype none
// ============================================================================
// prod_accum : accumulates a programmed count of unsigned products into a wide
//              running sum and offers it on a valid/ready handshake.
// Revision   : 1.0
// ============================================================================
module prod_accum #(
  parameter int PROD_W = 64,
  parameter int CNT_W  = 8,
  parameter int ACC_W  = 72
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic              sum_valid,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf,
  input  logic              sum_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_remaining;
  logic               r_ovf;
  logic               r_prod_ready;
  logic               r_sum_valid;
  logic               r_busy;
  logic [ACC_W:0]     w_sum_ext;

  // One extra bit on top of the accumulator captures the carry-out.
  assign w_sum_ext = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_remaining  <= '0;
      r_ovf        <= 1'b0;
      r_prod_ready <= 1'b0;
      r_sum_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_remaining <= len;
            r_busy      <= 1'b1;
            if (len != '0) begin
              r_state      <= S_ACCUM;
              r_prod_ready <= 1'b1;
            end else begin
              r_state     <= S_HOLD;
              r_sum_valid <= 1'b1;
            end
          end
        end
        S_ACCUM: begin
          if (prod_valid) begin
            r_acc       <= w_sum_ext[ACC_W-1:0];
            r_ovf       <= r_ovf | w_sum_ext[ACC_W];
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == CNT_W'(1)) begin
              r_state      <= S_HOLD;
              r_prod_ready <= 1'b0;
              r_sum_valid  <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (sum_ready) begin
            r_state     <= S_IDLE;
            r_sum_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_prod_ready <= 1'b0;
          r_sum_valid  <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign prod_ready = r_prod_ready;
  assign sum_valid  = r_sum_valid;
  assign sum        = r_acc;
  assign ovf        = r_ovf;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_prod_accum.sv
`default_nettype none
// ============================================================================
// tb_prod_accum : directed bench for prod_accum (default and 64-bit acc).
// Revision      : 1.0
// ============================================================================
module tb_prod_accum;
  localparam int PW = 64;
  localparam int CW = 8;
  localparam int AW = 72;

  logic          CLK = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          start64 = 1'b0;
  logic          prod_valid = 1'b0;
  logic          sum_ready = 1'b0;
  logic [CW-1:0] len = '0;
  logic [PW-1:0] prod = '0;

  logic          prod_ready, sum_valid, ovf, busy;
  logic [AW-1:0] sum;
  logic          prod_ready64, sum_valid64, ovf64, busy64;
  logic [63:0]   sum64;

  int            n_err = 0;
  int            n_chk = 0;
  int            lat;
  logic [72:0]   sb[$];
  logic [63:0]   prods[$];

  prod_accum #(.PROD_W(PW), .CNT_W(CW), .ACC_W(AW)) u_dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .len(len),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready),
    .sum_valid(sum_valid), .sum(sum), .ovf(ovf),
    .sum_ready(sum_ready), .busy(busy)
  );

  prod_accum #(.PROD_W(PW), .CNT_W(CW), .ACC_W(64)) u_dut64 (
    .CLK(CLK), .rst_n(rst_n), .start(start64), .len(len),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready64),
    .sum_valid(sum_valid64), .sum(sum64), .ovf(ovf64),
    .sum_ready(sum_ready), .busy(busy64)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drives one job; the bench model folds each product into m and pushes the
  // expected result when the last product is driven.
  task automatic run_job(input bit s64, input int n, input int stall, input int hold,
                         output int lt);
    logic [72:0] m;
    logic        mo;
    logic [72:0] e;
    int          g;
    m  = '0;
    mo = 1'b0;
    len = CW'(n);
    if (s64) start64 = 1'b1;
    else     start   = 1'b1;
    tick();
    start = 1'b0;
    start64 = 1'b0;
    lt = 1;
    chk("busy_after_start", s64 ? busy64 : busy, 1);
    chk("prod_ready_after_start", s64 ? prod_ready64 : prod_ready, (n != 0));
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int j = 0; j < stall; j++) begin
          prod_valid = 1'b0;
          tick();
          lt++;
        end
      end
      prod_valid = 1'b1;
      prod = prods[i];
      m = m + {9'b0, prods[i]};
      if (s64) begin
        mo = mo | m[64];
        m[72:64] = '0;
      end else begin
        mo = mo | m[72];
        m[72] = 1'b0;
      end
      tick();
      lt++;
    end
    prod_valid = 1'b0;
    sb.push_back({mo, m[71:0]});
    g = 0;
    while (!(s64 ? sum_valid64 : sum_valid) && g < 8) begin
      tick();
      lt++;
      g++;
    end
    chk("sum_valid_rise_delay", g, 0);
    e = sb.pop_front();
    for (int h = 0; h <= hold; h++) begin
      chk("sum_valid_held", s64 ? sum_valid64 : sum_valid, 1);
      chk("sum", s64 ? {64'b0, sum64} : {56'b0, sum}, {56'b0, e[71:0]});
      chk("ovf", s64 ? ovf64 : ovf, e[72]);
      if (h < hold) tick();
    end
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    chk("sum_valid_drop", s64 ? sum_valid64 : sum_valid, 0);
    chk("busy_drop", s64 ? busy64 : busy, 0);
  endtask

  initial begin
    repeat (2) tick();
    chk("reset_outputs", {prod_ready, sum_valid, busy, ovf, sum}, 0);
    chk("reset_outputs64", {prod_ready64, sum_valid64, busy64, ovf64, sum64}, 0);
    rst_n = 1'b1;
    tick();

    prods = '{64'd4, 64'd72, 64'd10000};
    run_job(1'b0, 3, 0, 0, lat);
    chk("basic_latency", lat, 4);

    prods = '{64'd5, 64'd7};
    run_job(1'b0, 2, 3, 4, lat);
    chk("stall_latency", lat, 6);

    run_job(1'b0, 0, 0, 0, lat);
    chk("empty_latency", lat, 1);

    prods = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2};
    run_job(1'b1, 2, 0, 0, lat);
    prods = '{64'd3};
    run_job(1'b1, 1, 0, 0, lat);

    // Start pulsed mid-job must not reload the count; then reset aborts.
    len = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    prod_valid = 1'b1;
    prod = 64'd6;
    tick();
    prod_valid = 1'b0;
    len = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored_remaining", u_dut.r_remaining, 2);
    chk("still_accum", prod_ready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {prod_ready, sum_valid, busy, ovf, sum}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("no_partial_sum", sum_valid, 0);
    prods = '{64'd9};
    run_job(1'b0, 1, 0, 0, lat);

    prods.delete();
    repeat (255) prods.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    run_job(1'b0, 255, 0, 0, lat);
    chk("full_latency", lat, 256);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/prod_accum.md
# prod_accum

Downstream consumer of the 64-bit product `C` from `bin_mult`. Accumulates a programmed number of unsigned products into a wide running sum and presents the result through a valid/ready handshake. Holds the sum until it is taken. Upstream logic aligns `prod_valid` to `bin_mult`'s output latency; this block does not track multiplier latency.

## Interface
Parameters:
- `PROD_W`, default 64: product width; matches `bin_mult` output `C`.
- `CNT_W`, default 8: width of the product-count field `len`.
- `ACC_W`, default 72: accumulator width. Must satisfy ACC_W >= PROD_W.

Ports (clock and reset first):
- `CLK` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a new accumulation; sampled only in IDLE.
- `len` in CNT_W: number of products to accumulate; sampled with `start`.
- `prod_valid` in 1: `prod` is valid this cycle.
- `prod` in PROD_W: unsigned product, typically `bin_mult.C`.
- `prod_ready` out 1: block accepts a product this cycle.
- `sum_valid` out 1: `sum` and `ovf` are valid.
- `sum` out ACC_W: accumulated result.
- `ovf` out 1: sticky flag; the accumulator wrapped during this job.
- `sum_ready` in 1: consumer takes `sum`.
- `busy` out 1: state is not IDLE.

## Operation
- Three states: IDLE, ACCUM, HOLD. Registers: `acc` (ACC_W), `remaining` (CNT_W), `ovf`.
- IDLE:
  - `prod_ready`=0, `sum_valid`=0.
  - `start`=1 with `len`!=0 → clear `acc` and `ovf`, load `remaining`=`len`, go to ACCUM.
  - `start`=1 with `len`==0 → clear `acc` and `ovf`, go directly to HOLD (empty job, `sum`=0).
- ACCUM:
  - `prod_ready`=1.
  - Accept occurs when `prod_valid` and `prod_ready` are both 1. On accept: `acc` <= (`acc` + zero-extended `prod`) mod 2^ACC_W; `ovf` <= `ovf` OR carry-out; `remaining` decrements.
  - Accept with `remaining`==1 → go to HOLD.
  - Cycles with `prod_valid`=0 are stalls; nothing changes.
- HOLD:
  - `sum_valid`=1, `prod_ready`=0.
  - `sum`, `ovf` held stable until `sum_ready`=1, then go to IDLE.
- `start` is ignored in ACCUM and HOLD, including the cycle HOLD exits.
- `sum` is driven directly from `acc`. It is meaningful only while `sum_valid`=1.
- All arithmetic is unsigned. No saturation: the sum wraps, and `ovf` records it.
- With default parameters, overflow is impossible: 255 × (2^64−1) < 2^72.

## Timing
- Reset (async assert, state change without a clock edge): state=IDLE; `acc`, `remaining`, `ovf` = 0; `prod_ready`, `sum_valid`, `busy` = 0; `sum`=0.
- Reset release takes effect at the next rising edge of `CLK`.
- Reset asserted mid-job aborts the job. No partial sum is ever presented.
- `start` edge → `prod_ready`=1 on the next cycle.
- Throughput: one product per cycle.
- `sum_valid` rises one cycle after the last accepted product, with the final sum already in `sum`.
- Empty job: `sum_valid`=1 one cycle after `start`.
- HOLD exit: `sum_valid`=0 the cycle after `sum_ready` is sampled high.
- Minimum gap between jobs is one IDLE cycle.
- `busy` is a registered state decode: high from the cycle after `start` through the last HOLD cycle.

## Test plan
- Basic sum: `len`=3, products 4, 72, 10000 (2×2, 8×9, 100×100) on consecutive cycles, `sum_ready`=1 → `sum_valid` one cycle after the third accept, `sum`=10076, `ovf`=0, then IDLE.
- Stalls and backpressure: `len`=2, products 5 and 7 separated by 3 `prod_valid`=0 cycles; hold `sum_ready`=0 for 4 cycles → `sum`=12 stable the whole time; `sum_valid` drops the cycle after `sum_ready`=1.
- Empty job: `start` with `len`=0 → `sum_valid`=1 next cycle, `sum`=0, `ovf`=0. No product is accepted; `prod_ready` stays 0.
- Overflow, ACC_W=64: `len`=2, products 0xFFFF_FFFF_FFFF_FFFF and 2 → `sum`=1, `ovf`=1. Next job with `len`=1, product 3 → `sum`=3, `ovf`=0.
- Ignored start and mid-job reset: pulse `start` during ACCUM → no effect on `remaining`. Assert `rst_n`=0 after 1 of 3 products → all outputs 0 immediately. After release, job `len`=1, product 9 → `sum`=9.
- Full count: `len`=255, each product 0xFFFF_FFFF_FFFF_FFFF → `sum`=255×(2^64−1), `ovf`=0, `sum_valid` exactly 256 cycles after `start`.
